// File: rtl/writeback_arbiter.sv
`default_nettype none
// writeback_arbiter: round-robin selection of one execution-unit result per cycle onto the
// register-bank write port, with a registered output stage and register-0 write filtering. Rev 1.0
module writeback_arbiter #(
  parameter int NUM_UNITS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter bit ALLOW_WRITE_P0 = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_UNITS-1:0]                  wb_valid,
  input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0]  wb_addr,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  wb_data,
  output logic [NUM_UNITS-1:0]                  wb_ack,
  output logic [ADDR_WIDTH-1:0]                 write_addr,
  output logic [DATA_WIDTH-1:0]                 new_data,
  output logic                                  commit,
  output logic                                  p0_drop
);

  localparam int             PTR_W = $clog2(NUM_UNITS);
  localparam logic [PTR_W:0] NUM_U = (PTR_W+1)'(NUM_UNITS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_UNITS - 1);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [PTR_W:0]        cand;
  logic                  drop_p0;
  logic                  commit_q, commit_d;
  logic                  p0_drop_q, p0_drop_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] new_data_q, new_data_d;

  // Scan from ptr upward with wrap; the first valid unit found wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= NUM_U) begin
        cand = cand - NUM_U;
      end
      if (!grant_valid && wb_valid[cand[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Ack is suppressed while reset is held so a pending request is neither acked nor committed.
  always_comb begin
    wb_ack = '0;
    if (grant_valid && rst) begin
      wb_ack[grant_idx] = 1'b1;
    end
  end

  assign drop_p0 = (wb_addr[grant_idx] == '0) && !ALLOW_WRITE_P0;

  always_comb begin
    ptr_d        = ptr_q;
    commit_d     = grant_valid && !drop_p0;
    p0_drop_d    = grant_valid && drop_p0;
    write_addr_d = write_addr_q;
    new_data_d   = new_data_q;
    if (grant_valid) begin
      ptr_d        = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      write_addr_d = wb_addr[grant_idx];
      new_data_d   = wb_data[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= '0;
      commit_q     <= 1'b0;
      p0_drop_q    <= 1'b0;
      write_addr_q <= '0;
      new_data_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      commit_q     <= commit_d;
      p0_drop_q    <= p0_drop_d;
      write_addr_q <= write_addr_d;
      new_data_q   <= new_data_d;
    end
  end

  assign commit     = commit_q;
  assign p0_drop    = p0_drop_q;
  assign write_addr = write_addr_q;
  assign new_data   = new_data_q;

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Selects one completed result per cycle from up to NUM_UNITS execution units and drives the single write port (write_addr / new_data / commit) of the physical register bank. Sits directly upstream of the register bank in the writeback stage. Round-robin fair, one registered output stage, and filters writes to physical register 0.

## Interface

**Parameters**
- NUM_UNITS, 4: number of writeback sources; must be ≥ 2.
- DATA_WIDTH, 32: result width; matches the register bank.
- ALLOW_WRITE_P0, 0: when 0, requests targeting physical register 0 are acked but never committed.

**Ports**
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous and active-low.
- wb_valid, in, [NUM_UNITS]: unit i holds a result.
- wb_addr, in, phys_addr_t [NUM_UNITS]: destination physical register of unit i.
- wb_data, in, [DATA_WIDTH] [NUM_UNITS]: result of unit i.
- wb_ack, out, [NUM_UNITS]: unit i's result is accepted this cycle; one-hot or zero.
- write_addr, out, phys_addr_t: to register bank.
- new_data, out, DATA_WIDTH: to register bank.
- commit, out, 1: register bank write enable.
- p0_drop, out, 1: one-cycle pulse when a register-0 request was discarded.

## Operation

- **Request rule.** A unit asserts wb_valid with wb_addr/wb_data stable, and holds them until it samples wb_ack=1 on a clock edge. It may present a new result in the cycle after the ack.
- **Grant.**
  - Combinational round-robin over wb_valid, starting at priority pointer ptr (width $clog2(NUM_UNITS)).
  - The first valid index at or after ptr, with wrap-around, is granted.
  - wb_ack[grant] = 1 in the same cycle; all other acks = 0.
  - No valid requests: wb_ack = 0 and ptr is unchanged.
- **Pointer update.** On a grant, ptr <= (grant + 1) mod NUM_UNITS; this wraps from NUM_UNITS-1 to 0.
- **Output register.** Updated every cycle.
  - commit <= grant_valid && !(wb_addr[grant] == 0 && !ALLOW_WRITE_P0).
  - write_addr <= wb_addr[grant] and new_data <= wb_data[grant] whenever grant_valid; otherwise they hold their previous values.
  - p0_drop <= grant_valid && wb_addr[grant] == 0 && !ALLOW_WRITE_P0.
- **No backpressure.** The register bank accepts a write every cycle, so throughput is one result per cycle.
- **Duplicate destinations.** Two units targeting the same register in consecutive cycles commit in grant order; the later grant wins in the bank.
- **Reset.** rst=0 asynchronously forces:
  - commit=0, p0_drop=0, write_addr=0, new_data=0, ptr=0.
  - wb_ack is forced to 0 while rst=0.
  - A request pending when reset asserts is not acked and not committed.
  - After release, arbitration restarts from unit 0.

## Timing

- **Latency.** Ack is in cycle N, combinational from wb_valid. commit/write_addr/new_data are valid in cycle N+1 and the bank holds the data at edge N+2, so readable from cycle N+2.
- **Output hold.** commit is high for exactly one cycle per accepted non-dropped request.
- **Back-to-back grants.** Continuous grants produce commit high every cycle.
- **No combinational paths** from wb_valid to commit, write_addr, new_data or p0_drop.
- **Worst-case wait.** With all units requesting continuously, a unit waits at most NUM_UNITS-1 cycles for its ack.
- **Zero-register drop.** A dropped register-0 request consumes its grant slot, advances ptr, and pulses p0_drop in N+1 with commit=0.

## Test plan

- **Reset values.** Hold rst=0 with all wb_valid=1.
  - wb_ack=0, commit=0, write_addr=0, new_data=0, p0_drop=0.
  - Release: in the first cycle, unit 0 is acked.
- **Single request.** Unit 2 requests addr 5, data 0xDEADBEEF in cycle N.
  - wb_ack=4'b0100 in cycle N.
  - commit=1, write_addr=5, new_data=0xDEADBEEF in N+1.
  - commit=0 in N+2.
- **Fairness.** All 4 units hold valid continuously from ptr=0.
  - Acks go 0,1,2,3,0,… with commit high every cycle.
  - Unit 3 drops valid after its ack: the sequence becomes 0,1,2,0.
- **Pointer wrap.** ptr=3 with only units 1 and 3 valid.
  - Unit 3 is granted, then unit 1; ptr is 0 after the first grant and 2 after the second.
- **Zero-register filter.** ALLOW_WRITE_P0=0, unit 1 requests addr 0.
  - Acked in N; commit=0 and p0_drop=1 in N+1.
  - With ALLOW_WRITE_P0=1: commit=1 and p0_drop=0.
- **Reset mid-operation.** Assert rst=0 asynchronously between edges while unit 0 is acked and commit=1.
  - commit and wb_ack drop immediately; no write occurs at the following edge.
  - After release, unit 0 (still valid) is re-granted first.
